// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC chain feeder: FSM state encoding,
// default geometry and the accumulator width rule.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD_A,
    LOAD_B,
    RUN,
    DRAIN,
    DONE
  } feeder_state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ROWS       = 8;
  localparam int DEF_COLS       = 8;

  // Wide enough for COLS <= 2**data_width products of two data_width operands.
  function automatic int acc_width(input int data_width);
    return 3 * data_width;
  endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Small synchronous FIFO with a combinational head, used for the A rows and
// the B vector of the MAC feeder.
module feeder_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + CNTW'(1);
      else if (pop && !push) count <= count - CNTW'(1);
    end
  end

  // NOTE: storage is not reset; the count alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mac_feeder.sv
// Sequencer for the MAC chain: loads matrix A and vector B from one byte
// stream, then streams B into MAC0 and skewed A rows into every MAC.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  output logic                       clr_out,
  output logic                       en_out,
  output logic [DATA_WIDTH-1:0]      b_out,
  output logic [ROWS*DATA_WIDTH-1:0] a_out,
  output logic                       busy,
  output logic                       done
);

  localparam int CW = $clog2(ROWS * COLS + 1);
  localparam logic [CW-1:0] LAST_COL   = CW'(COLS - 1);
  localparam logic [CW-1:0] LAST_ROW   = CW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(COLS + ROWS - 2);

  feeder_state_t state, next_state;
  logic [CW-1:0] cnt;      // column in loads, RUN-relative cycle in RUN/DRAIN
  logic [CW-1:0] row_cnt;
  logic          en_q;
  logic          accept;
  logic          run_phase;

  logic                  b_push, b_pop, b_full, b_empty;
  logic [DATA_WIDTH-1:0] b_head;

  assign accept    = in_valid && in_ready;
  assign run_phase = (state == RUN) || (state == DRAIN);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CLEAR;
      CLEAR:   next_state = LOAD_A;
      LOAD_A:  if (accept && row_cnt == LAST_ROW && cnt == LAST_COL) next_state = LOAD_B;
      LOAD_B:  if (accept && cnt == LAST_COL) next_state = RUN;
      RUN:     if (cnt == LAST_COL) next_state = (ROWS == 1) ? DONE : DRAIN;
      DRAIN:   if (cnt == LAST_DRAIN) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      row_cnt <= '0;
      en_q    <= 1'b0;
    end else begin
      state <= next_state;
      en_q  <= (next_state == RUN);
      case (state)
        LOAD_A: if (accept) begin
          if (cnt == LAST_COL) begin
            cnt     <= '0;
            row_cnt <= row_cnt + CW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LOAD_B: if (accept) cnt <= (cnt == LAST_COL) ? '0 : cnt + CW'(1);
        RUN, DRAIN: cnt <= (next_state == DONE) ? '0 : cnt + CW'(1);
        default: begin
          cnt     <= '0;
          row_cnt <= '0;
        end
      endcase
    end
  end

  assign in_ready = (state == LOAD_A) || (state == LOAD_B);
  assign clr_out  = (state == CLEAR);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign en_out   = en_q;
  assign b_out    = en_q ? b_head : '0;

  assign b_push = (state == LOAD_B) && accept;
  assign b_pop  = en_q;

  feeder_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(COLS)) u_b_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (b_push),
    .pop   (b_pop),
    .din   (in_data),
    .head  (b_head),
    .full  (b_full),
    .empty (b_empty)
  );

  b_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(b_push && b_full));
  b_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(b_pop && b_empty));

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic                  a_push, a_pop, a_full, a_empty;
    logic [DATA_WIDTH-1:0] a_head;
    logic [CW:0]           rel;   // window index of row r; MSB set while still before it

    assign rel    = {1'b0, cnt} - (CW + 1)'(r);
    assign a_pop  = run_phase && !rel[CW] && (rel < (CW + 1)'(COLS));
    assign a_push = (state == LOAD_A) && accept && (row_cnt == CW'(r));

    feeder_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(COLS)) u_a_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (a_push),
      .pop   (a_pop),
      .din   (in_data),
      .head  (a_head),
      .full  (a_full),
      .empty (a_empty)
    );

    assign a_out[r*DATA_WIDTH +: DATA_WIDTH] = a_pop ? a_head : '0;

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(a_push && a_full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(a_pop && a_empty));
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench: a 2x3 and a default 8x8 feeder, each driving a behavioural
// MAC chain whose accumulators are compared against hand-computed results.
module tb_mac_feeder;
  import mac_pkg::*;

  localparam int AW = acc_width(8);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // small instance: ROWS=2, COLS=3
  logic        s_start, s_valid, s_ready, s_clr, s_en, s_busy, s_done;
  logic [7:0]  s_data, s_b;
  logic [15:0] s_a;
  // default instance: ROWS=8, COLS=8
  logic        d_start, d_valid, d_ready, d_clr, d_en, d_busy, d_done;
  logic [7:0]  d_data, d_b;
  logic [63:0] d_a;

  mac_feeder #(.DATA_WIDTH(8), .ROWS(2), .COLS(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid), .in_data(s_data),
    .in_ready(s_ready), .clr_out(s_clr), .en_out(s_en), .b_out(s_b), .a_out(s_a),
    .busy(s_busy), .done(s_done)
  );

  mac_feeder dut_d (
    .clk(clk), .rst_n(rst_n), .start(d_start), .in_valid(d_valid), .in_data(d_data),
    .in_ready(d_ready), .clr_out(d_clr), .en_out(d_en), .b_out(d_b), .a_out(d_a),
    .busy(d_busy), .done(d_done)
  );

  // Behavioural MAC chains: en/b hop one MAC per cycle, a_in is per MAC.
  logic [AW-1:0] s_c [2];
  logic          s_ep [2];
  logic [7:0]    s_bp [2];
  logic [AW-1:0] d_c [8];
  logic          d_ep [8];
  logic [7:0]    d_bp [8];

  always @(posedge clk or negedge rst_n) begin
    logic       e;
    logic [7:0] bb;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin s_c[i] <= '0; s_ep[i] <= 1'b0; s_bp[i] <= '0; end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (i == 0) begin e = s_en; bb = s_b; end
        else begin e = s_ep[i-1]; bb = s_bp[i-1]; end
        s_ep[i] <= e;
        s_bp[i] <= bb;
        if (s_clr) s_c[i] <= '0;
        else if (e) s_c[i] <= s_c[i] + AW'(s_a[i*8 +: 8]) * AW'(bb);
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    logic       e;
    logic [7:0] bb;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin d_c[i] <= '0; d_ep[i] <= 1'b0; d_bp[i] <= '0; end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (i == 0) begin e = d_en; bb = d_b; end
        else begin e = d_ep[i-1]; bb = d_bp[i-1]; end
        d_ep[i] <= e;
        d_bp[i] <= bb;
        if (d_clr) d_c[i] <= '0;
        else if (e) d_c[i] <= d_c[i] + AW'(d_a[i*8 +: 8]) * AW'(bb);
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [7:0]  job_a   [64];
  logic [7:0]  job_b   [8];
  logic [31:0] job_exp [8];

  task automatic drive(input bit big, input logic st, input logic v, input logic [7:0] dat);
    if (big) begin d_start = st; d_valid = v; d_data = dat; end
    else     begin s_start = st; s_valid = v; s_data = dat; end
  endtask

  function automatic logic rdy_of(input bit big);   return big ? d_ready : s_ready; endfunction
  function automatic logic clr_of(input bit big);   return big ? d_clr   : s_clr;   endfunction
  function automatic logic en_of(input bit big);    return big ? d_en    : s_en;    endfunction
  function automatic logic busy_of(input bit big);  return big ? d_busy  : s_busy;  endfunction
  function automatic logic done_of(input bit big);  return big ? d_done  : s_done;  endfunction
  function automatic logic [7:0] b_of(input bit big); return big ? d_b : s_b; endfunction
  function automatic logic [7:0] a_of(input bit big, input int i);
    return big ? d_a[i*8 +: 8] : s_a[i*8 +: 8];
  endfunction
  function automatic logic [31:0] c_of(input bit big, input int i);
    if (big) return 32'(d_c[i]);
    if (i < 2) return 32'(s_c[i]);
    return 32'hFFFF_FFFF;
  endfunction
  function automatic logic any_out(input bit big);
    if (big) return |{d_ready, d_clr, d_en, d_b, d_a, d_busy, d_done};
    return |{s_ready, s_clr, s_en, s_b, s_a, s_busy, s_done};
  endfunction

  // One job from start to done. gap toggles in_valid, poke pulses start in
  // LOAD_A, keep leaves start high at done, abort_at resets at RUN+abort_at.
  task automatic run_job(input bit big, input int rows, input int cols, input bit gap,
                         input bit poke, input bit keep, input int abort_at, input int exp_lat);
    logic [7:0] beats [72];
    int  nb, idx, n, k;
    bit  seen, drop, got;
    logic v;
    nb = rows * cols + cols;
    for (int i = 0; i < rows * cols; i++) beats[i] = job_a[i];
    for (int j = 0; j < cols; j++) beats[rows*cols + j] = job_b[j];

    @(negedge clk);
    drive(big, 1'b1, 1'b0, 8'h00);
    got = 0;
    for (n = 0; n < 4; n++) begin
      if (clr_of(big)) begin got = 1; break; end
      @(negedge clk);
    end
    check("clr_pulse", 32'(got), 1);
    check("ready_in_clear", 32'(rdy_of(big)), 0);
    check("busy_in_clear", 32'(busy_of(big)), 1);
    drive(big, 1'b0, 1'b0, 8'h00);
    @(negedge clk);

    idx = 0; k = 0; seen = 0; drop = 0;
    while (idx < nb && k < 400) begin
      v = gap ? 1'(k % 2 == 0) : 1'b1;
      drive(big, 1'(poke && idx == 2), v, v ? beats[idx] : 8'hEE);
      if (seen && !rdy_of(big)) drop = 1;
      if (v && rdy_of(big)) begin idx++; seen = 1; end
      k++;
      @(negedge clk);
    end
    drive(big, 1'b0, 1'b0, 8'h00);
    check("beats_accepted", 32'(idx), 32'(nb));
    check("ready_held", 32'(drop), 0);

    got = 0;
    for (n = 0; n < 4; n++) begin
      if (en_of(big)) begin got = 1; break; end
      @(negedge clk);
    end
    check("run_start", 32'(got), 1);
    check("run_gap", 32'(n), 0);
    check("b_t0", 32'(b_of(big)), 32'(job_b[0]));
    if (!big) begin
      check("a0_t0", 32'(a_of(big, 0)), 32'(job_a[0]));
      check("a1_before_window", 32'(a_of(big, 1)), 0);
    end

    if (abort_at >= 0) begin
      repeat (abort_at) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_outputs", 32'(any_out(big)), 0);
      @(negedge clk);
      check("rst_held_outputs", 32'(any_out(big)), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_idle", 32'(busy_of(big)), 0);
      check("rst_no_en", 32'(en_of(big)), 0);
      return;
    end

    @(negedge clk);
    n = 1;
    if (!big) check("a1_t1", 32'(a_of(big, 1)), 32'(job_a[cols]));
    got = 0;
    while (n < 64) begin
      if (done_of(big)) begin got = 1; break; end
      n++;
      @(negedge clk);
    end
    check("done_seen", 32'(got), 1);
    check("done_latency", 32'(n), 32'(exp_lat));
    for (int i = 0; i < rows; i++) check($sformatf("c%0d", i), c_of(big, i), job_exp[i]);
    check("busy_in_done", 32'(busy_of(big)), 1);
    if (keep) drive(big, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("done_one_cycle", 32'(done_of(big)), 0);
    check("idle_after_done", 32'(busy_of(big)), 0);
    check("c_hold", c_of(big, rows - 1), job_exp[rows - 1]);
  endtask

  task automatic set_case1();
    for (int i = 0; i < 6; i++) job_a[i] = 8'(i + 1);
    job_b[0] = 8'd7; job_b[1] = 8'd8; job_b[2] = 8'd9;
    job_exp[0] = 32'd50; job_exp[1] = 32'd122;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check("reset_small", 32'(any_out(1'b0)), 0);
    check("reset_default", 32'(any_out(1'b1)), 0);
    rst_n = 1'b1;

    // 1: 2x3 reference job
    set_case1();
    run_job(1'b0, 2, 3, 1'b0, 1'b0, 1'b0, -1, 4);

    // 2: 8x8, A all ones, B = 1..8
    for (int i = 0; i < 64; i++) job_a[i] = 8'd1;
    for (int j = 0; j < 8; j++) begin job_b[j] = 8'(j + 1); job_exp[j] = 32'd36; end
    run_job(1'b1, 8, 8, 1'b0, 1'b0, 1'b0, -1, 15);

    // 3: case 1 with in_valid toggling
    set_case1();
    run_job(1'b0, 2, 3, 1'b1, 1'b0, 1'b0, -1, 4);

    // 4: 8x8 all 255
    for (int i = 0; i < 64; i++) job_a[i] = 8'd255;
    for (int j = 0; j < 8; j++) begin job_b[j] = 8'd255; job_exp[j] = 32'd520200; end
    run_job(1'b1, 8, 8, 1'b0, 1'b0, 1'b0, -1, 15);

    // 5: reset at RUN+2, then a clean case-1 job
    set_case1();
    run_job(1'b0, 2, 3, 1'b0, 1'b0, 1'b0, 2, 4);
    run_job(1'b0, 2, 3, 1'b0, 1'b0, 1'b0, -1, 4);

    // 6: start poked during LOAD_A, then a back-to-back job with B = [1,1,1]
    set_case1();
    run_job(1'b0, 2, 3, 1'b0, 1'b1, 1'b1, -1, 4);
    job_b[0] = 8'd1; job_b[1] = 8'd1; job_b[2] = 8'd1;
    job_exp[0] = 32'd6; job_exp[1] = 32'd15;
    run_job(1'b0, 2, 3, 1'b0, 1'b0, 1'b0, -1, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
